rx_fifo: RTL and testbench
==========================

Name: rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It consumes the receiver's frame-complete strobe and parallel byte, which live in the baud-tick domain. It synchronises the strobe into the system clock domain and stores each received frame in a circular FIFO. The host or command logic drains it through a first-word-fall-through read port, with status flags and a sticky overrun flag.

Parameters:
NBITS, 8, data width per frame; must match the receiver's NBITS.
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
clk  in  1  system clock; frequency ≥ 4× bdtick frequency.
rx_rst  in  1  reset, asynchronous, active-low.
rx_done  in  1  frame-complete level from receiver, bdtick domain; high for ≥ 1 bdtick period.
rx_data  in  NBITS  received byte; stable from rx_done rise until the next start bit (quasi-static, not synchronised).
rd_en  in  1  pop request; honoured only when rd_valid=1.
rd_data  out  NBITS  head entry, mem[rd_ptr], combinational from storage (FWFT).
rd_valid  out  1  = !empty.
empty  out  1  count==0.
full  out  1  count==DEPTH.
count  out  AW+1  occupied entries, 0..DEPTH.
overrun  out  1  sticky: a frame arrived while full.
ovr_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rx_rst=0): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overrun=0, sync flops=0, edge register=0. Memory contents are not reset; rd_data is don't-care while empty.
- Reset release mid-frame: if rx_done is already high, the edge register starts at 0. That high level therefore produces at most one write, after synchronisation.
- Strobe path: rx_done feeds a 2-flop synchroniser (s1, s2) and an edge register p. Define wstb = s2 & !p.
- Strobe latency: wstb is high for exactly 1 clk per rx_done rising edge. The write commits at the 3rd clk edge that samples rx_done high. empty/rd_valid update after that edge.
- Write capture: at wstb, rx_data is written to mem[wr_ptr]. rx_data is sampled directly at that edge.
- Pointers wrap modulo DEPTH (natural AW-bit overflow). count is tracked separately, so full and empty are unambiguous.
- Operation table per clk (w = wstb accepted, r = rd_en & !empty):
  - w only: write, wr_ptr+1, count+1.
  - r only: rd_ptr+1, count−1.
  - w & r, not full: both happen, count unchanged.
  - w & r, full: the read frees one slot and the write is accepted. count stays DEPTH, overrun is not set.
  - w & r, empty: write only. The read is ignored (no bypass) and rd_valid rises the next cycle.
  - wstb while full with no read (default build): frame dropped, pointers and count unchanged, overrun<=1.
- rd_en while empty: ignored, no pointer change, no error flag.
- overrun stays set until ovr_clr=1. If ovr_clr and a new overrun event occur in the same cycle, set wins.
- All outputs except rd_data are registered or decoded from registers. rd_data depends only on rd_ptr and memory.

Optional Feature:
Macro RX_FIFO_DROP_OLDEST_EN.
- Defined: wstb while full and not reading overwrites the oldest entry. mem[wr_ptr] is written, wr_ptr+1, rd_ptr+1, count stays DEPTH, overrun<=1. The newest DEPTH frames are kept.
- Undefined: the default drop-newest behaviour above applies.
- All other behaviour is identical in both builds.

Decomposition:
- Package rx_pkg holds:
  - UART_NBITS=8 and RXF_DEPTH=16 defaults.
  - The ptr_t / cnt_t width localparams derived from DEPTH.
  - A shared localparam set used by both the receiver and rx_fifo so that NBITS matches.
- One sub-module, sync_2ff: generic single-bit 2-flop synchroniser with the same async active-low reset. It is reused later by the transmit-side handshake.
- Memory, pointer, and flag logic stay inline in rx_fifo.

Test Plan:
1. Reset then three frames 0xA5, 0x3C, 0xFF, with rx_done pulses one bdtick wide and bdtick = clk/16 → count 1→2→3. Each write occurs 3 clk after rx_done rises. Popping gives A5, 3C, FF in order, and empty=1 after the 3rd pop.
2. Fill 16 frames 0x00..0x0F, then a 17th frame 0x55 → full=1, overrun=1, count=16, and the pops return 0x00..0x0F. With RX_FIFO_DROP_OLDEST_EN they return 0x01..0x0F then 0x55.
3. Full FIFO: rd_en asserted in the same clk as wstb for 0x77 → count stays 16, overrun stays 0, and 0x77 is the last entry popped.
4. Empty FIFO: rd_en held high while frame 0x42 arrives → no pop on the write cycle. rd_valid=1 next clk with rd_data=0x42, and it is popped the following clk.
5. rx_rst asserted mid-sequence with count=5, and rx_done high across reset release → all outputs return to reset values immediately. At most one write of the current rx_data occurs after release.
6. overrun set, then ovr_clr pulsed in the same clk as a new drop → overrun stays 1. A later ovr_clr alone → overrun=0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared receive-path constants: frame width and FIFO depth defaults used by
// both the UART receiver and rx_fifo, so the two always agree on NBITS.
// Also provides pointer/count/data types sized from the default depth.
package rx_pkg;

  localparam int UART_NBITS = 8;
  localparam int RXF_DEPTH  = 16;
  localparam int RXF_AW     = $clog2(RXF_DEPTH);

  typedef logic [RXF_AW-1:0]     ptr_t;
  typedef logic [RXF_AW:0]       cnt_t;
  typedef logic [UART_NBITS-1:0] data_t;

endpackage

// File: rtl/rx_fifo_if.sv
// rx_fifo bus bundle: receiver strobe/data in, FWFT read port and status out.
// master = upstream/host side (drives rx_done, rx_data, rd_en, ovr_clr);
// slave  = rx_fifo (drives rd_data, rd_valid, empty, full, count, overrun).
interface rx_fifo_if
  import rx_pkg::*;
#(
  parameter int NBITS = UART_NBITS,
  parameter int DEPTH = RXF_DEPTH
) ();

  localparam int AW = $clog2(DEPTH);

  logic             rx_done;
  logic [NBITS-1:0] rx_data;
  logic             rd_en;
  logic             ovr_clr;
  logic [NBITS-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overrun;

  modport master (
    output rx_done, rx_data, rd_en, ovr_clr,
    input  rd_data, rd_valid, empty, full, count, overrun
  );

  modport slave (
    input  rx_done, rx_data, rd_en, ovr_clr,
    output rd_data, rd_valid, empty, full, count, overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser into the clk domain.
// Latency: 2 clk. No backpressure (free-running level path).
// Ports: clk, rst_n (async active-low), d_i (async level), q_o (synchronised).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO: syncs the receiver's rx_done level, stores one entry per rising edge.
// Latency: write commits on the 3rd clk edge sampling rx_done high; FWFT read (rd_data comb).
// Backpressure: none upstream; when full a new frame is dropped and overrun set
// (macro RX_FIFO_DROP_OLDEST_EN: overwrite the oldest entry instead, overrun still set).
// Ports: clk, rx_rst (async active-low), bus (rx_fifo_if.slave: rx_done/rx_data in,
// rd_en/ovr_clr in, rd_data/rd_valid/empty/full/count/overrun out).
module rx_fifo
  import rx_pkg::*;
#(
  parameter int NBITS = UART_NBITS,
  parameter int DEPTH = RXF_DEPTH
) (
  input  logic       clk,
  input  logic       rx_rst,
  rx_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] fptr_t;
  typedef logic [AW:0]   fcnt_t;

  localparam fcnt_t FULL_CNT = fcnt_t'(DEPTH);

  logic             s2;
  logic             p_q;
  logic             wstb;
  logic [NBITS-1:0] mem_q [DEPTH];
  fptr_t            wr_ptr_q, wr_ptr_d;
  fptr_t            rd_ptr_q, rd_ptr_d;
  fcnt_t            count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             is_empty, is_full;
  logic             rd_ok, ovr_evt, do_wr, do_rd;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rx_rst),
    .d_i   (bus.rx_done),
    .q_o   (s2)
  );

  // Edge register resets to 0, so a level already high at reset release
  // still yields exactly one strobe once it has crossed the synchroniser.
  always_ff @(posedge clk or negedge rx_rst) begin
    if (!rx_rst) p_q <= 1'b0;
    else         p_q <= s2;
  end

  assign wstb     = s2 & ~p_q;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  always_comb begin
    rd_ok   = bus.rd_en & ~is_empty;
    // A simultaneous read frees a slot, so only a read-less write into a full FIFO overflows.
    ovr_evt = wstb & is_full & ~rd_ok;
`ifdef RX_FIFO_DROP_OLDEST_EN
    do_wr   = wstb;
    do_rd   = rd_ok | ovr_evt;
`else
    do_wr   = wstb & ~ovr_evt;
    do_rd   = rd_ok;
`endif
    wr_ptr_d  = wr_ptr_q + fptr_t'(do_wr);
    rd_ptr_d  = rd_ptr_q + fptr_t'(do_rd);
    count_d   = count_q + fcnt_t'(do_wr) - fcnt_t'(do_rd);
    // Set has priority over clear.
    overrun_d = ovr_evt | (overrun_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk or negedge rx_rst) begin
    if (!rx_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; rx_data is quasi-static and sampled directly here.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.rd_valid = ~is_empty;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed table/sequences plus random traffic,
// every cycle compared against a queue-based model of the FIFO.
module tb_rx_fifo;
  import rx_pkg::*;

  localparam int NB = UART_NBITS;
  localparam int DP = RXF_DEPTH;
`ifdef RX_FIFO_DROP_OLDEST_EN
  localparam bit DROP_OLDEST = 1'b1;
`else
  localparam bit DROP_OLDEST = 1'b0;
`endif

  typedef logic [NB-1:0] byte_t;
  typedef struct {
    byte_t dat;
    int    cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rx_rst;
  always #5 clk = ~clk;

  rx_fifo_if #(.NBITS(NB), .DEPTH(DP)) bus ();
  rx_fifo #(.NBITS(NB), .DEPTH(DP)) dut (.clk(clk), .rx_rst(rx_rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: FIFO contents as a queue, overrun flag, and the rx_done edge history.
  byte_t mq[$];
  bit    m_ovr;
  bit    m_prev;
  int    m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b0;
    m_pend = 0;
  endtask

  // One clk edge: a rising rx_done lands in the FIFO on the 3rd edge that sees it high.
  task automatic model_edge();
    bit    w;
    bit    r;
    bit    ev;
    byte_t d;
    d  = bus.rx_data;
    w  = 1'b0;
    ev = 1'b0;
    if (m_pend > 0) begin
      m_pend--;
      w = (m_pend == 0);
    end
    if (bus.rx_done && !m_prev) m_pend = 2;
    m_prev = bus.rx_done;
    r = bus.rd_en && (mq.size() > 0);
    if (w && mq.size() == DP && !r) begin
      ev = 1'b1;
      if (DROP_OLDEST) begin
        void'(mq.pop_front());
        mq.push_back(d);
      end
    end else begin
      if (r) void'(mq.pop_front());
      if (w) mq.push_back(d);
    end
    if (ev) m_ovr = 1'b1;
    else if (bus.ovr_clr) m_ovr = 1'b0;
  endtask

  task automatic check_state();
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DP));
    chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
    chk("overrun",  32'(bus.overrun),  32'(m_ovr));
    if (mq.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rx_rst) model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic frame(input byte_t d, input int hi, input int lo);
    bus.rx_data = d;
    bus.rx_done = 1'b1;
    repeat (hi) tick();
    bus.rx_done = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pop_expect(input string name, input byte_t exp);
    chk(name, 32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic rnd_ticks(input int k, input int rd_pct);
    for (int i = 0; i < k; i++) begin
      bus.rd_en   = ($urandom_range(0, 99) < rd_pct);
      bus.ovr_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
  endtask

  vec_t  tv[3];
  byte_t exp2[DP];
  byte_t d;

  initial begin
    tv[0] = '{dat: 8'hA5, cnt: 1};
    tv[1] = '{dat: 8'h3C, cnt: 2};
    tv[2] = '{dat: 8'hFF, cnt: 3};
    for (int i = 0; i < DP; i++)
      exp2[i] = (DROP_OLDEST) ? ((i == DP - 1) ? 8'h55 : byte_t'(i + 1)) : byte_t'(i);

    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    rx_rst      = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    rx_rst = 1'b1;
    tick();

    // 1: three frames, bdtick = 16 clk; write on the 3rd edge after rise.
    for (int i = 0; i < 3; i++) begin
      bus.rx_data = tv[i].dat;
      bus.rx_done = 1'b1;
      repeat (2) tick();
      chk("t1_before_write", 32'(bus.count), 32'(tv[i].cnt - 1));
      tick();
      chk("t1_after_write", 32'(bus.count), 32'(tv[i].cnt));
      repeat (13) tick();
      bus.rx_done = 1'b0;
      repeat (16) tick();
    end
    for (int i = 0; i < 3; i++) pop_expect("t1_pop", tv[i].dat);
    chk("t1_empty", 32'(bus.empty), 32'd1);

    // 2: fill 16, then a 17th frame while full.
    for (int i = 0; i < DP; i++) frame(byte_t'(i), 8, 8);
    frame(8'h55, 8, 8);
    chk("t2_full",    32'(bus.full),    32'd1);
    chk("t2_overrun", 32'(bus.overrun), 32'd1);
    chk("t2_count",   32'(bus.count),   32'd16);
    for (int i = 0; i < DP; i++) pop_expect("t2_pop", exp2[i]);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t2_ovr_cleared", 32'(bus.overrun), 32'd0);

    // 3: full FIFO, read in the same clk as the write of 0x77.
    for (int i = 0; i < DP; i++) frame(byte_t'(8'h10 + i), 8, 8);
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1;
    repeat (2) tick();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t3_count",   32'(bus.count),   32'd16);
    chk("t3_overrun", 32'(bus.overrun), 32'd0);
    repeat (5) tick();
    bus.rx_done = 1'b0;
    repeat (8) tick();
    for (int i = 1; i < DP; i++) pop_expect("t3_pop", byte_t'(8'h10 + i));
    pop_expect("t3_last_77", 8'h77);
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // 4: rd_en held high on an empty FIFO while 0x42 arrives.
    bus.rd_en   = 1'b1;
    bus.rx_data = 8'h42;
    bus.rx_done = 1'b1;
    repeat (3) tick();
    chk("t4_valid", 32'(bus.rd_valid), 32'd1);
    chk("t4_data",  32'(bus.rd_data),  32'h42);
    chk("t4_count", 32'(bus.count),    32'd1);
    tick();
    chk("t4_popped", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;
    repeat (12) tick();
    bus.rx_done = 1'b0;
    repeat (8) tick();

    // 5: async reset with 5 entries and rx_done high across release.
    for (int i = 0; i < 5; i++) frame(byte_t'(8'h60 + i), 8, 8);
    chk("t5_pre_count", 32'(bus.count), 32'd5);
    bus.rx_data = 8'h99;
    bus.rx_done = 1'b1;
    tick();
    #2;
    rx_rst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_count", 32'(bus.count),    32'd0);
    chk("t5_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("t5_rst_empty", 32'(bus.empty),    32'd1);
    repeat (2) tick();
    rx_rst = 1'b1;
    repeat (12) tick();
    bus.rx_done = 1'b0;
    repeat (8) tick();
    chk("t5_one_write", 32'(bus.count),   32'd1);
    chk("t5_data",      32'(bus.rd_data), 32'h99);

    // 6: overrun set wins over a same-cycle clear; later clear alone works.
    for (int i = 1; i < DP; i++) frame(byte_t'(8'h80 + i), 8, 8);
    frame(8'hE1, 8, 8);
    chk("t6_ovr_set", 32'(bus.overrun), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t6_ovr_clr1", 32'(bus.overrun), 32'd0);
    bus.rx_data = 8'hE2;
    bus.rx_done = 1'b1;
    repeat (2) tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t6_set_wins", 32'(bus.overrun), 32'd1);
    repeat (5) tick();
    bus.rx_done = 1'b0;
    repeat (8) tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t6_clear", 32'(bus.overrun), 32'd0);
    bus.rd_en = 1'b1;
    repeat (DP + 2) tick();
    bus.rd_en = 1'b0;
    chk("t6_drained", 32'(bus.empty), 32'd1);

    // Random traffic: slow reads first to reach full/overrun, then fast drain.
    for (int n = 0; n < 60; n++) begin
      d = byte_t'($urandom);
      bus.rx_data = d;
      bus.rx_done = 1'b1;
      rnd_ticks($urandom_range(4, 12), (n < 30) ? 5 : 60);
      bus.rx_done = 1'b0;
      rnd_ticks($urandom_range(4, 12), (n < 30) ? 5 : 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
